// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings, default width
// and a width helper used to size the bit-index counter.
package sub_defs;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Ceiling log2, clamped to 1 so a single-bit counter still exists at WIDTH=1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_full_sub_cell.sv
// One-bit full subtractor built from two half-subtractor cells and an OR.
// Purely combinational; the borrow register sits in the controller.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs0_d;
    logic hs0_b;
    logic hs1_b;

    // First half-subtractor: a - b
    assign hs0_d = a ^ b;
    assign hs0_b = ~a & b;

    // Second half-subtractor: (a - b) - bin
    assign d     = hs0_d ^ bin;
    assign hs1_b = ~hs0_d & bin;

    assign bout  = hs0_b | hs1_b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor controller: accepts A,B, streams them LSB-first
// through one full-subtractor cell with a registered borrow, and returns A-B and the borrow.
module serial_sub_ctrl
    import sub_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             busy
);

    localparam int CNT_W = clog2(WIDTH);

    state_t             state_reg;
    state_t             state_next;

    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [WIDTH-1:0]   diff_sh_reg;
    logic [WIDTH-1:0]   diff_next;
    logic [WIDTH-1:0]   diff_out_reg;
    logic               bor_reg;
    logic               borrow_out_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               cell_d;
    logic               cell_bout;
    logic               last_bit;

    full_sub_cell u_cell (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (bor_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 is the LSB result.
    assign diff_next = WIDTH'({cell_d, diff_sh_reg} >> 1);
    assign last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:  state_next = in_valid  ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_next = last_bit  ? ST_DONE  : ST_SHIFT;
            ST_DONE:  state_next = out_ready ? ST_IDLE  : ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_reg)
            ST_IDLE:  in_ready = 1'b1;
            ST_SHIFT: busy     = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Datapath: operands load only on an accepted handshake; results latch on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg       <= '0;
            b_sh_reg       <= '0;
            diff_sh_reg    <= '0;
            bor_reg        <= 1'b0;
            cnt_reg        <= '0;
            diff_out_reg   <= '0;
            borrow_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_reg    <= a_in;
                        b_sh_reg    <= b_in;
                        diff_sh_reg <= '0;
                        bor_reg     <= 1'b0;
                        cnt_reg     <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sh_reg    <= a_sh_reg >> 1;
                    b_sh_reg    <= b_sh_reg >> 1;
                    diff_sh_reg <= diff_next;
                    bor_reg     <= cell_bout;
                    cnt_reg     <= cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        diff_out_reg   <= diff_next;
                        borrow_out_reg <= cell_bout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff_out   = diff_out_reg;
    assign borrow_out = borrow_out_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: directed cases plus randomized traffic on
// WIDTH=8, WIDTH=1 and WIDTH=32 instances, checked against plain A-B / A<B arithmetic.
module tb_serial_sub_ctrl;

    localparam int N_RAND = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff_out;
    logic       borrow_out;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit rand_go = 1'b0;
    bit lane_done [2];

    logic [7:0] exp_d [$];
    logic       exp_b [$];
    int         exp_acc [$];
    logic       prev_v = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub_ctrl #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff_out   (diff_out),
        .borrow_out (borrow_out),
        .busy       (busy)
    );

    task automatic chk(input bit ok, input string name, input longint got, input longint exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at the negedge that precedes the accepting posedge.
    task automatic push8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = a - b;
        exp_d.push_back(d);
        exp_b.push_back(a < b);
        exp_acc.push_back(cyc + 1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_v) begin
                if (exp_acc.size() == 0)
                    chk(1'b0, "w8 unexpected_valid", 1, 0);
                else
                    chk((cyc - exp_acc[0]) == 8, "w8 latency", cyc - exp_acc[0], 8);
            end
            if (out_valid && out_ready && exp_d.size() > 0) begin
                logic [7:0] ed;
                logic       eb;
                ed = exp_d.pop_front();
                eb = exp_b.pop_front();
                void'(exp_acc.pop_front());
                $display("w8 result diff=%02h borrow=%0d (model diff=%02h borrow=%0d)",
                         diff_out, borrow_out, ed, eb);
                chk(diff_out == ed, "w8 diff", longint'(diff_out), longint'(ed));
                chk(borrow_out == eb, "w8 borrow", longint'(borrow_out), longint'(eb));
            end
        end
        prev_v = out_valid;
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push8(a, b);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(1'b0, "w8 accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_d.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(1'b0, "w8 idle_timeout", 0, 1);
    endtask

    initial begin
        bit ok;
        bit acc;
        int sent;
        rst = 1'b1;
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(out_valid == 1'b0, "reset out_valid", longint'(out_valid), 0);
        chk(busy == 1'b0, "reset busy", longint'(busy), 0);
        chk(in_ready == 1'b1, "reset in_ready", longint'(in_ready), 1);
        chk(diff_out == 8'h00, "reset diff_out", longint'(diff_out), 0);
        chk(borrow_out == 1'b0, "reset borrow_out", longint'(borrow_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        send(8'h05, 8'h03);
        wait_idle();
        send(8'h03, 8'h05);
        send(8'hFF, 8'h00);
        wait_idle();

        // Back-pressure: result must hold while out_ready is low and new operands are refused
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h5A, 8'h21);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(1'b0, "bp valid_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            a_in = 8'h11;
            b_in = 8'h22;
            @(negedge clk);
            chk(out_valid == 1'b1, "bp out_valid", longint'(out_valid), 1);
            chk(diff_out == 8'h39, "bp diff_out", longint'(diff_out), 8'h39);
            chk(in_ready == 1'b0, "bp in_ready", longint'(in_ready), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk(in_ready == 1'b1, "bp release in_ready", longint'(in_ready), 1);
        chk(out_valid == 1'b0, "bp release out_valid", longint'(out_valid), 0);
        chk(busy == 1'b0, "bp release busy", longint'(busy), 0);
        chk(diff_out == 8'h39, "bp retained diff", longint'(diff_out), 8'h39);

        // Reset during the third SHIFT cycle drops the operation
        send(8'h3C, 8'h0F);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_d.delete();
        exp_b.delete();
        exp_acc.delete();
        @(negedge clk);
        chk(out_valid == 1'b0, "rst out_valid", longint'(out_valid), 0);
        chk(busy == 1'b0, "rst busy", longint'(busy), 0);
        chk(in_ready == 1'b1, "rst in_ready", longint'(in_ready), 1);
        chk(diff_out == 8'h00, "rst diff_out", longint'(diff_out), 0);
        send(8'h80, 8'h01);
        wait_idle();

        send(8'h00, 8'h00);
        send(8'h00, 8'h01);
        wait_idle();

        // Randomized traffic with input gaps and output stalls
        rand_go = 1'b1;
        sent = 0;
        acc = 1'b0;
        ok = 1'b0;
        for (int it = 0; it < 60000; it++) begin
            if (sent >= N_RAND && exp_d.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            acc = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < N_RAND && $urandom_range(0, 2) != 0) begin
                int m;
                in_valid = 1'b1;
                m = $urandom_range(0, 7);
                a_in = (m == 0) ? 8'h00 : (m == 1) ? 8'hFF : 8'($urandom);
                m = $urandom_range(0, 7);
                b_in = (m == 0) ? 8'h00 : (m == 1) ? 8'hFF : 8'($urandom);
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                push8(a_in, b_in);
                sent++;
                acc = 1'b1;
            end
        end
        if (!ok) chk(1'b0, "w8 random_timeout", longint'(sent), N_RAND);

        ok = 1'b0;
        for (int i = 0; i < 90000; i++) begin
            if (lane_done[0] && lane_done[1]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk(1'b0, "lane_timeout", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int LW = (gi == 0) ? 1 : 32;

        logic          iv;
        logic          ir;
        logic [LW-1:0] ai;
        logic [LW-1:0] bi;
        logic          ov;
        logic          orr;
        logic [LW-1:0] dout;
        logic          bo;
        logic          by;
        logic          pv = 1'b0;

        logic [LW-1:0] qd [$];
        logic          qb [$];
        int            qa [$];

        serial_sub_ctrl #(.WIDTH(LW)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (iv),
            .in_ready   (ir),
            .a_in       (ai),
            .b_in       (bi),
            .out_valid  (ov),
            .out_ready  (orr),
            .diff_out   (dout),
            .borrow_out (bo),
            .busy       (by)
        );

        always @(negedge clk) begin
            if (!rst) begin
                if (ov && !pv) begin
                    if (qa.size() == 0)
                        chk(1'b0, $sformatf("w%0d unexpected_valid", LW), 1, 0);
                    else
                        chk((cyc - qa[0]) == LW, $sformatf("w%0d latency", LW), cyc - qa[0], LW);
                end
                if (ov && orr && qd.size() > 0) begin
                    logic [LW-1:0] ed;
                    logic          eb;
                    ed = qd.pop_front();
                    eb = qb.pop_front();
                    void'(qa.pop_front());
                    $display("w%0d result diff=%0h borrow=%0d (model diff=%0h borrow=%0d)",
                             LW, dout, bo, ed, eb);
                    chk(dout == ed, $sformatf("w%0d diff", LW), longint'(dout), longint'(ed));
                    chk(bo == eb, $sformatf("w%0d borrow", LW), longint'(bo), longint'(eb));
                end
            end
            pv = ov;
        end

        initial begin
            int  sent;
            bit  acc;
            bit  ok;
            logic [LW-1:0] d;
            iv = 1'b0;
            ai = '0;
            bi = '0;
            orr = 1'b0;
            lane_done[gi] = 1'b0;
            sent = 0;
            acc = 1'b0;
            ok = 1'b0;
            wait (rand_go);
            for (int it = 0; it < 80000; it++) begin
                if (sent >= N_RAND && qd.size() == 0) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge clk); #1;
                if (acc) iv = 1'b0;
                acc = 1'b0;
                orr = ($urandom_range(0, 3) != 0);
                if (!iv && sent < N_RAND && $urandom_range(0, 2) != 0) begin
                    iv = 1'b1;
                    ai = LW'($urandom);
                    bi = ($urandom_range(0, 7) == 0) ? ai : LW'($urandom);
                end
                @(negedge clk);
                if (iv && ir) begin
                    d = ai - bi;
                    qd.push_back(d);
                    qb.push_back(ai < bi);
                    qa.push_back(cyc + 1);
                    sent++;
                    acc = 1'b1;
                end
            end
            if (!ok) chk(1'b0, $sformatf("w%0d random_timeout", LW), longint'(sent), N_RAND);
            lane_done[gi] = 1'b1;
        end
    end

endmodule
